// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-access stage (stage_mem_lsu).
// State encodings, func3 access codes and the misalignment rule live here.
package lsu_pkg;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 3'd0;
    localparam lsu_state_t ST_REQ   = 3'd1;
    localparam lsu_state_t ST_RSP   = 3'd2;
    localparam lsu_state_t ST_DRAIN = 3'd3;
    localparam lsu_state_t ST_DONE  = 3'd4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        logic mis;
        case (func3)
            F3_LH, F3_LHU: mis = off[0];
            F3_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for stage_mem_lsu: load extract/extend and
// store byte-enable / lane-replicated write data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    input  logic [2:0]  st_func3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] load_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_wdata
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        case (ld_off)
            2'd0:    ld_byte_s = rdata[7:0];
            2'd1:    ld_byte_s = rdata[15:8];
            2'd2:    ld_byte_s = rdata[23:16];
            2'd3:    ld_byte_s = rdata[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        ld_half_s = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_func3)
            F3_LB:   load_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LBU:  load_data = {24'h000000, ld_byte_s};
            F3_LH:   load_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LHU:  load_data = {16'h0000, ld_half_s};
            F3_LW:   load_data = rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store lanes; the half enable ignores off[0] so an unaligned SH lands on the truncated half.
    always_comb begin
        case (st_func3)
            F3_SB: begin
                store_be    = 4'b0001 << st_off;
                store_wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                store_be    = 4'b0011 << {st_off[1], 1'b0};
                store_wdata = {2{st_data[15:0]}};
            end
            F3_SW: begin
                store_be    = 4'hF;
                store_wdata = st_data;
            end
            default: begin
                store_be    = 4'h0;
                store_wdata = st_data;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// Memory-access pipeline stage: req/gnt + rvalid data-memory handshake with stall.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into a no-request trap.
module stage_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_RegWrite,
    input  logic              in_wed,
    input  logic [1:0]        in_result_src,
    input  logic [2:0]        in_func3,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_write_data,
    input  logic [31:0]       in_pc_plus_4,
    input  logic [4:0]        in_a_wr,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic              o_stall,
    output logic [31:0]       o_read_data,
    output logic              o_misalign,
    output logic              o_RegWrite,
    output logic              o_wed,
    output logic [1:0]        o_result_src,
    output logic [31:0]       o_alu_result,
    output logic [31:0]       o_pc_plus_4,
    output logic [4:0]        o_a_wr,
    output logic [2:0]        o_func3
);

    lsu_state_t        state_q, state_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [3:0]        dm_be_q, dm_be_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              misalign_q, misalign_d;
    logic [2:0]        ld_func3_q, ld_func3_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic              memop_s;
    logic              trap_s;
    logic [31:0]       load_data_s;
    logic [3:0]        store_be_s;
    logic [31:0]       store_wdata_s;

    assign memop_s = in_valid & (in_wed | (in_result_src == RESULT_SRC_LOAD));
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s  = is_misaligned(in_func3, in_alu_result[1:0]);
`else
    assign trap_s  = 1'b0;
`endif

    lsu_align u_align (
        .ld_func3    (ld_func3_q),
        .ld_off      (ld_off_q),
        .rdata       (dm_rdata),
        .st_func3    (in_func3),
        .st_off      (in_alu_result[1:0]),
        .st_data     (in_write_data),
        .load_data   (load_data_s),
        .store_be    (store_be_s),
        .store_wdata (store_wdata_s)
    );

    // Next-state and next-register computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        read_data_d = read_data_q;
        misalign_d  = misalign_q;
        ld_func3_d  = ld_func3_q;
        ld_off_d    = ld_off_q;
        case (state_q)
            ST_IDLE: begin
                if (memop_s && !flush) begin
                    ld_func3_d = in_func3;
                    ld_off_d   = in_alu_result[1:0];
                    if (trap_s) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        dm_req_d   = 1'b1;
                        dm_we_d    = in_wed;
                        dm_addr_d  = {in_alu_result[ADDR_W-1:2], 2'b00};
                        dm_be_d    = in_wed ? store_be_s : 4'hF;
                        dm_wdata_d = in_wed ? store_wdata_s : 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An accepted request is committed even if flushed in the same cycle.
                if (dm_gnt) begin
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    if (dm_we_q) begin
                        state_d = flush ? ST_IDLE : ST_DONE;
                    end else begin
                        state_d = flush ? ST_DRAIN : ST_RSP;
                    end
                end else if (flush) begin
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RSP: begin
                if (dm_rvalid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        read_data_d = load_data_s;
                        state_d     = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RSP;
                end
            end
            ST_DRAIN: begin
                if (dm_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                misalign_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                dm_req_d   = 1'b0;
                dm_we_d    = 1'b0;
                misalign_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Stage state and data-memory request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= 4'h0;
            dm_wdata_q  <= 32'h0000_0000;
            read_data_q <= 32'h0000_0000;
            misalign_q  <= 1'b0;
            ld_func3_q  <= 3'b000;
            ld_off_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
            read_data_q <= read_data_d;
            misalign_q  <= misalign_d;
            ld_func3_q  <= ld_func3_d;
            ld_off_q    <= ld_off_d;
        end
    end

    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_be       = dm_be_q;
    assign dm_wdata    = dm_wdata_q;
    assign o_read_data = read_data_q;
    assign o_misalign  = misalign_q;

    assign o_stall = ((state_q == ST_IDLE) && memop_s && !flush) ||
                     (state_q == ST_REQ) || (state_q == ST_RSP) || (state_q == ST_DRAIN);

`ifdef LSU_MISALIGN_TRAP_EN
    assign o_RegWrite = in_RegWrite & ~((state_q == ST_DONE) & misalign_q);
`else
    assign o_RegWrite = in_RegWrite;
`endif
    assign o_wed        = in_wed;
    assign o_result_src = in_result_src;
    assign o_alu_result = in_alu_result;
    assign o_pc_plus_4  = in_pc_plus_4;
    assign o_a_wr       = in_a_wr;
    assign o_func3      = in_func3;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Self-checking bench for stage_mem_lsu: directed vector table, handshake corner
// sequences and randomized accesses against a behavioural model.
module tb_stage_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_RegWrite, in_wed;
    logic [1:0]  in_result_src;
    logic [2:0]  in_func3;
    logic [31:0] in_alu_result, in_write_data, in_pc_plus_4;
    logic [4:0]  in_a_wr;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        o_stall, o_misalign, o_RegWrite, o_wed;
    logic [31:0] o_read_data, o_alu_result, o_pc_plus_4;
    logic [1:0]  o_result_src;
    logic [4:0]  o_a_wr;
    logic [2:0]  o_func3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_read;

    stage_mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_RegWrite(in_RegWrite), .in_wed(in_wed), .in_result_src(in_result_src),
        .in_func3(in_func3), .in_alu_result(in_alu_result), .in_write_data(in_write_data),
        .in_pc_plus_4(in_pc_plus_4), .in_a_wr(in_a_wr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .o_stall(o_stall), .o_read_data(o_read_data), .o_misalign(o_misalign),
        .o_RegWrite(o_RegWrite), .o_wed(o_wed), .o_result_src(o_result_src),
        .o_alu_result(o_alu_result), .o_pc_plus_4(o_pc_plus_4), .o_a_wr(o_a_wr),
        .o_func3(o_func3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference rules written from the access definitions with plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned a,
                                             input logic [31:0] rd);
        int unsigned v;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * a)) % 256;
                if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * (a / 2))) % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            3'd2:    v = rd;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input int unsigned a);
        int unsigned b;
        if (!st) b = 15;
        else if (f3 == 3'd0) b = 1 << a;
        else if (f3 == 3'd1) b = 3 << (2 * (a / 2));
        else if (f3 == 3'd2) b = 15;
        else b = 0;
        return b[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd % 256) * 32'h0101_0101;
        else if (f3 == 3'd1) return (wd % 65536) * 32'h0001_0001;
        else return wd;
    endfunction

    function automatic logic ref_trap(input logic [2:0] f3, input int unsigned a);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && a != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One access with a responder granting after gd request cycles and returning rvalid rvd cycles later.
    task automatic do_access(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd,
                             input logic rw, output int stalls, output logic req_seen,
                             output logic [31:0] a_o, output logic [3:0] be_o, output logic [31:0] wd_o,
                             output logic we_o, output logic stable, output logic [31:0] rdat,
                             output logic mis, output logic rw_o, output logic timeout);
        int req_n = 0;
        int rv_n  = 0;
        logic granted = 1'b0;
        in_valid = 1'b1; in_wed = st; in_result_src = st ? 2'b00 : 2'b01;
        in_func3 = f3; in_alu_result = addr; in_write_data = wd; in_RegWrite = rw;
        dm_rdata = rd; dm_gnt = 1'b0; dm_rvalid = 1'b0;
        stalls = 0; req_seen = 1'b0; stable = 1'b1; timeout = 1'b1;
        a_o = 32'h0; be_o = 4'h0; wd_o = 32'h0; we_o = 1'b0;
        rdat = 32'h0; mis = 1'b0; rw_o = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!o_stall) begin
                rdat = o_read_data; mis = o_misalign; rw_o = o_RegWrite; timeout = 1'b0;
                break;
            end
            stalls++;
            dm_gnt = 1'b0; dm_rvalid = 1'b0;
            if (dm_req) begin
                if (!req_seen) begin
                    a_o = dm_addr; be_o = dm_be; wd_o = dm_wdata; we_o = dm_we;
                end else if (dm_addr !== a_o || dm_be !== be_o || dm_wdata !== wd_o || dm_we !== we_o) begin
                    stable = 1'b0;
                end
                req_seen = 1'b1;
                if (req_n == gd) begin dm_gnt = 1'b1; granted = 1'b1; end
                req_n++;
            end else if (granted && !st) begin
                if (rv_n == rvd) dm_rvalid = 1'b1;
                rv_n++;
            end
            @(posedge clk);
        end
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(posedge clk);
        in_valid = 1'b0; in_wed = 1'b0; in_result_src = 2'b00;
        #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_read;
        int          exp_stall;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int stalls;
        logic req_seen, we_o, stable, mis, rw_o, timeout;
        logic [31:0] a_o, wd_o, rdat;
        logic [3:0] be_o;

        tbl[0] = '{3'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 32'h0000_1000, 4'hF, 32'h0, 32'hFFFF_FF80, 3};
        tbl[1] = '{3'd4, 1'b0, 32'h0000_1001, 32'h0, 32'h1234_5678, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_0056, 3};
        tbl[2] = '{3'd1, 1'b0, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 32'h0000_1000, 4'hF, 32'h0, 32'hFFFF_8001, 3};
        tbl[3] = '{3'd5, 1'b0, 32'h0000_1000, 32'h0, 32'h8001_F00D, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_F00D, 3};
        tbl[4] = '{3'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 32'h0000_1004, 4'hF, 32'h0, 32'hDEAD_BEEF, 3};
        tbl[5] = '{3'd0, 1'b1, 32'h0000_2001, 32'h0000_00A5, 32'h0, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 2};
        tbl[6] = '{3'd1, 1'b1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'hDEAD_BEEF, 2};
        tbl[7] = '{3'd2, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 32'h0000_2004, 4'hF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 2};
        tbl[8] = '{3'd3, 1'b0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFF, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_0000, 3};
        tbl[9] = '{3'd0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_007F, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_007F, 3};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_RegWrite = 1'b0; in_wed = 1'b0;
        in_result_src = 2'b00; in_func3 = 3'b000; in_alu_result = 32'h0; in_write_data = 32'h0;
        in_pc_plus_4 = 32'h0; in_a_wr = 5'd0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        #12;
        check("reset dm_req", {31'h0, dm_req}, 32'h0);
        check("reset dm_we", {31'h0, dm_we}, 32'h0);
        check("reset dm_addr", dm_addr, 32'h0);
        check("reset dm_be", {28'h0, dm_be}, 32'h0);
        check("reset dm_wdata", dm_wdata, 32'h0);
        check("reset read_data", o_read_data, 32'h0);
        check("reset misalign", {31'h0, o_misalign}, 32'h0);
        check("reset stall", {31'h0, o_stall}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].f3, tbl[i].st, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, 0, 0, 1'b1,
                      stalls, req_seen, a_o, be_o, wd_o, we_o, stable, rdat, mis, rw_o, timeout);
            check($sformatf("vec%0d timeout", i), {31'h0, timeout}, 32'h0);
            check($sformatf("vec%0d stall cycles", i), stalls, tbl[i].exp_stall);
            check($sformatf("vec%0d dm_addr", i), a_o, tbl[i].exp_addr);
            check($sformatf("vec%0d dm_be", i), {28'h0, be_o}, {28'h0, tbl[i].exp_be});
            check($sformatf("vec%0d dm_we", i), {31'h0, we_o}, {31'h0, tbl[i].st});
            if (tbl[i].st) check($sformatf("vec%0d dm_wdata", i), wd_o, tbl[i].exp_wdata);
            check($sformatf("vec%0d read_data", i), rdat, tbl[i].exp_read);
        end
        last_read = 32'h0000_007F;

        // LW with grant withheld for five request cycles.
        do_access(3'd2, 1'b0, 32'h0000_3000, 32'h0, 32'h0BAD_F00D, 5, 0, 1'b1,
                  stalls, req_seen, a_o, be_o, wd_o, we_o, stable, rdat, mis, rw_o, timeout);
        check("gnt-wait stable", {31'h0, stable}, 32'h1);
        check("gnt-wait stall cycles", stalls, 8);
        check("gnt-wait dm_addr", a_o, 32'h0000_3000);
        check("gnt-wait read_data", rdat, 32'h0BAD_F00D);
        last_read = 32'h0BAD_F00D;

        // LHU flushed while waiting for the response: data must be drained and discarded.
        in_valid = 1'b1; in_wed = 1'b0; in_result_src = 2'b01; in_func3 = 3'd5;
        in_alu_result = 32'h0000_1002; dm_rdata = 32'h1234_5678; dm_gnt = 1'b0;
        #1 check("flush idle stall", {31'h0, o_stall}, 32'h1);
        @(posedge clk); #1;
        check("flush req", {31'h0, dm_req}, 32'h1);
        dm_gnt = 1'b1;
        @(posedge clk); #1 dm_gnt = 1'b0; flush = 1'b1;
        check("flush rsp stall", {31'h0, o_stall}, 32'h1);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; in_result_src = 2'b00;
        check("drain stall 1", {31'h0, o_stall}, 32'h1);
        @(posedge clk); #1 dm_rvalid = 1'b1;
        check("drain stall 2", {31'h0, o_stall}, 32'h1);
        @(posedge clk); #1 dm_rvalid = 1'b0;
        check("drain stall released", {31'h0, o_stall}, 32'h0);
        check("drain read_data kept", o_read_data, last_read);
        check("drain no req", {31'h0, dm_req}, 32'h0);

        // Misaligned LW.
        do_access(3'd2, 1'b0, 32'h0000_1002, 32'h0, 32'hAABB_CCDD, 0, 0, 1'b1,
                  stalls, req_seen, a_o, be_o, wd_o, we_o, stable, rdat, mis, rw_o, timeout);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misalign stalls", stalls, 1);
        check("misalign no req", {31'h0, req_seen}, 32'h0);
        check("misalign flag", {31'h0, mis}, 32'h1);
        check("misalign regwrite", {31'h0, rw_o}, 32'h0);
        check("misalign read_data", rdat, last_read);
`else
        check("misalign stalls", stalls, 3);
        check("misalign dm_addr", a_o, 32'h0000_1000);
        check("misalign flag", {31'h0, mis}, 32'h0);
        check("misalign regwrite", {31'h0, rw_o}, 32'h1);
        check("misalign read_data", rdat, 32'hAABB_CCDD);
        last_read = 32'hAABB_CCDD;
`endif

        // Randomized accesses against the reference rules.
        for (int i = 0; i < 40; i++) begin
            logic st, trap, rw;
            logic [2:0] f3;
            logic [31:0] addr, wd, rd, pc;
            logic [4:0] awr;
            int gd, rvd, exp_st;
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                4: f3 = 3'd5; 5: f3 = 3'd3; default: f3 = 3'd6;
            endcase
            if (st) f3 = 3'($urandom_range(0, 2));
            addr = $urandom & 32'h0000_FFFF; wd = $urandom; rd = $urandom;
            gd = $urandom_range(0, 3); rvd = $urandom_range(0, 2); rw = 1'($urandom_range(0, 1));
            pc = $urandom; awr = 5'($urandom_range(0, 31));
            in_pc_plus_4 = pc; in_a_wr = awr;
            trap = ref_trap(f3, addr % 4);
            do_access(f3, st, addr, wd, rd, gd, rvd, rw,
                      stalls, req_seen, a_o, be_o, wd_o, we_o, stable, rdat, mis, rw_o, timeout);
            if (trap) exp_st = 1;
            else if (st) exp_st = 2 + gd;
            else exp_st = 3 + gd + rvd;
            check($sformatf("rnd%0d stalls", i), stalls, exp_st);
            check($sformatf("rnd%0d req_seen", i), {31'h0, req_seen}, {31'h0, !trap});
            check($sformatf("rnd%0d misalign", i), {31'h0, mis}, {31'h0, trap});
            check($sformatf("rnd%0d regwrite", i), {31'h0, rw_o}, {31'h0, rw & !trap});
            check($sformatf("rnd%0d pc_plus_4", i), o_pc_plus_4, pc);
            check($sformatf("rnd%0d a_wr", i), {27'h0, o_a_wr}, {27'h0, awr});
            if (!trap) begin
                check($sformatf("rnd%0d stable", i), {31'h0, stable}, 32'h1);
                check($sformatf("rnd%0d dm_addr", i), a_o, addr - (addr % 4));
                check($sformatf("rnd%0d dm_be", i), {28'h0, be_o}, {28'h0, ref_be(st, f3, addr % 4)});
                check($sformatf("rnd%0d dm_we", i), {31'h0, we_o}, {31'h0, st});
                if (st) check($sformatf("rnd%0d dm_wdata", i), wd_o, ref_wdata(f3, wd));
                if (!st) last_read = ref_load(f3, addr % 4, rd);
            end
            check($sformatf("rnd%0d read_data", i), rdat, last_read);
        end

        // Asynchronous reset in the middle of a request.
        in_valid = 1'b1; in_wed = 1'b0; in_result_src = 2'b01; in_func3 = 3'd2;
        in_alu_result = 32'h0000_3000; dm_gnt = 1'b0;
        @(posedge clk); #1;
        check("pre-reset req", {31'h0, dm_req}, 32'h1);
        #3 rst_n = 1'b0; in_valid = 1'b0; in_result_src = 2'b00;
        #1;
        check("async reset dm_req", {31'h0, dm_req}, 32'h0);
        check("async reset stall", {31'h0, o_stall}, 32'h0);
        check("async reset read_data", o_read_data, 32'h0);
        check("async reset dm_be", {28'h0, dm_be}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset idle req", {31'h0, dm_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
